// File: rtl/uart_rx_mmio_if.sv
// MEM-stage load bus as seen by the UART receiver: address/strobe in, read data and status flags out.
interface uart_rx_mmio_if;
  logic [31:0] Address;
  logic        MemRead;
  logic [31:0] ReadData;
  logic        rx_valid;
  logic        overrun;

  modport master (output Address, MemRead, input ReadData, rx_valid, overrun);
  modport slave  (input Address, MemRead, output ReadData, rx_valid, overrun);
endinterface

// File: rtl/uart_rx_mmio.sv
// 8N1 UART receiver with a byte FIFO, read by the pipeline through RXDATA/STATUS load addresses.
module uart_rx_mmio #(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0018
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           rx,
  uart_rx_mmio_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [31:0]   STAT_ADDR = BASE_ADDR + 32'd4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  logic rx_meta_q, rxs_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     shreg_q, shreg_d;
  logic           push_req, ferr_set;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    push_req = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxs_q) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rxs_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shreg_d = {rxs_q, shreg_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // Leave at mid-stop-bit so a back-to-back start edge is not missed.
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          state_d  = IDLE;
          push_req = rxs_q;
          ferr_set = !rxs_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic        overrun_q, overrun_d, ferr_q, ferr_d;
  logic        empty, full, rd_data_sel, rd_stat_sel, pop, push_ok, drop;
  logic [7:0]  head;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head  = mem_q[rptr_q[AW-1:0]];

  assign rd_data_sel = bus.MemRead && (bus.Address == BASE_ADDR);
  assign rd_stat_sel = bus.MemRead && (bus.Address == STAT_ADDR);
  assign pop         = rd_data_sel && !empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign push_ok     = push_req && (!full || pop);
  assign drop        = push_req && full && !pop;

  always_comb begin
    wptr_d    = wptr_q + {{AW{1'b0}}, push_ok};
    rptr_d    = rptr_q + {{AW{1'b0}}, pop};
    overrun_d = drop     | (overrun_q & ~rd_stat_sel);
    ferr_d    = ferr_set | (ferr_q    & ~rd_stat_sel);
  end

  always_comb begin
    bus.ReadData = '0;
    if (rd_data_sel && !empty) bus.ReadData = {24'b0, head};
    else if (rd_stat_sel)      bus.ReadData = {28'b0, full, ferr_q, overrun_q, !empty};
  end

  assign bus.rx_valid = !empty;
  assign bus.overrun  = overrun_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      overrun_q <= overrun_d;
      ferr_q    <= ferr_d;
    end
  end

  // Storage only; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= shreg_q;
  end
endmodule

// File: doc/uart_rx_mmio.md
# uart_rx_mmio

Memory-mapped UART receiver: the input-side counterpart to the CPU's display output path. It deserialises 8N1 frames from the board's serial pin and buffers received bytes in a small FIFO. The pipeline reads them with ordinary `lw` loads, via the same Address/MemRead bus the MEM stage drives for data memory. Status flags let software poll for data and detect lost bytes.

## Interface
Parameters:
- CLKS_PER_BIT, 868, clock cycles per bit (100 MHz / 115200); must be ≥ 4 and even.
- FIFO_DEPTH, 8, byte entries; power of two, ≥ 2.
- BASE_ADDR, 32'h4000_0018, address of RXDATA; STATUS at BASE_ADDR+4.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low (reset==0 clears all state immediately).
- rx  in  1  serial line, idle high, asynchronous to clk.
- Address  in  32  MEM-stage byte address.
- MemRead  in  1  MEM-stage load strobe; one cycle per load.
- ReadData  out  32  combinational read data.
- rx_valid  out  1  FIFO non-empty.
- overrun  out  1  sticky: byte dropped because FIFO was full.

## Operation
- **Synchroniser:** rx passes through 2 flops (reset value 1). All logic uses the synchronised value rxs.
- **FSM states:** IDLE, START, DATA, STOP, with a bit counter cnt and a bit index idx[2:0].
- **IDLE:** when rxs==0, go to START with cnt=0.
- **START:** when cnt==CLKS_PER_BIT/2−1, sample rxs.
  - If 0, go to DATA with cnt=0, idx=0.
  - If 1 (glitch), go to IDLE with no flags.
- **DATA:** when cnt==CLKS_PER_BIT−1, shift rxs into shreg LSB-first and reset cnt.
  - After idx==7, go to STOP with cnt=0.
- **STOP:** when cnt==CLKS_PER_BIT−1, sample rxs and go to IDLE.
  - If 1, push shreg to the FIFO.
  - If 0, discard the byte and set frame_err (sticky).
  - Returning to IDLE at mid-stop-bit allows back-to-back frames.
- **Push with FIFO full and no pop that cycle:** drop the byte and set overrun.
- **Address decode (ReadData is 0 unless MemRead==1):**
  - Address==BASE_ADDR: ReadData={24'b0, head byte}, or 0 if empty.
    - The FIFO pops on that clock edge if non-empty.
    - A read while empty returns 0 with no state change.
  - Address==BASE_ADDR+4: ReadData={28'b0, full, frame_err, overrun, rx_valid}.
    - overrun and frame_err clear on that edge (read-to-clear).
  - Any other address: ReadData=0, no side effects.
- **Simultaneous push and pop:** both take effect and the count is unchanged. If full, the push is accepted with no overrun.
- **STATUS read in the same cycle a new error is detected:** the error stays set (set wins over clear).
- **FIFO structure:** circular buffer with read/write pointers of log2(FIFO_DEPTH)+1 bits. The pointers wrap naturally; full/empty are derived from the MSB comparison.

## Timing
- **Reset values:** FSM=IDLE, FIFO empty, rx_valid=0, overrun=0, frame_err=0, sync flops=1, ReadData=0 (with MemRead=0).
- **Reset mid-frame:** the partial byte is lost. Afterwards the receiver waits in IDLE for the next falling edge.
- **Latency from rx falling edge (cycle 0) to push:**
  - Sync delay: 2 cycles.
  - Start detect: 1 cycle.
  - Start sample: CLKS_PER_BIT/2.
  - Data bits and stop bit: 9×CLKS_PER_BIT.
  - rx_valid rises the cycle after the push edge (±1 cycle tolerance).
- **ReadData** is combinational from Address/MemRead and current FIFO state, valid in the same cycle. Pop and flag-clear are registered on that cycle's edge.
- **Held MemRead:** if MemRead is held high on RXDATA for N cycles, N pops occur. The pipeline must issue one strobe per load.

## Test plan
(All scenarios use CLKS_PER_BIT=16, FIFO_DEPTH=4.)
- **Single byte:** drive frame 0xA5 (8N1, 16 clk/bit) -> rx_valid=1 by ~150 cycles after the start edge. Read BASE_ADDR -> ReadData=32'h0000_00A5, rx_valid=0 next cycle. Re-read -> 0.
- **Back-to-back:** drive 0x01,0x02,0x03 with no idle gap -> STATUS=4'b0001. Three reads return 1,2,3 in order, then rx_valid=0.
- **Overrun:** send 5 bytes 0x10..0x14 with no reads -> STATUS=4'b1011 (full, overrun). Reads return 0x10..0x13. A second STATUS read -> 4'b0000.
- **Framing and glitch:**
  - Frame 0x55 with stop bit 0 -> no push, frame_err=1 (STATUS bit2).
  - A 3-cycle low glitch on rx -> no push, no flags, FSM back to IDLE.
- **Concurrency:** with the FIFO full, read RXDATA on the exact cycle of the stop-bit push -> count stays 4, overrun=0. A STATUS read coinciding with a framing error -> frame_err remains 1.
- **Async reset mid-frame:** pull reset low during bit 4 of 0xC3 -> rx_valid=0, ReadData=0 immediately. After release, a full 0x3C frame is received correctly.
